// File: rtl/int_control_n.sv
// int_control_n: N-channel interrupt concentrator with per-channel sync/edge detect,
// pending/overflow latching, fixed or round-robin grant and a stretched, acknowledged irq pulse.
module int_control_n #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_FALL = 0,
  parameter int PULSE_US    = 10,
  parameter int ACK_TO_US   = 1000,
  parameter int RR_MODE     = 0,
  localparam int IW         = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            t1us,
  input  logic [N_CH-1:0] int_in,
  input  logic [N_CH-1:0] mask,
  input  logic            ack,
  input  logic            clr_flags,
  output logic            irq_out,
  output logic [IW-1:0]   irq_id,
  output logic            busy,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overflow,
  output logic            ack_timeout
);
  typedef enum logic [1:0] {IDLE, PULSE, WAIT_ACK} state_t;
  state_t r_state, w_state;
  logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
  logic [N_CH-1:0] r_sd, r_pending, r_overflow, w_s, w_ev, w_clr;
  logic [15:0] r_cnt, w_cnt;
  logic r_acked, w_acked, r_to, w_to, w_grant;
  logic [IW-1:0] r_id, r_last, w_win, w_j;
  assign w_s = r_sync[SYNC_STAGES-1];
  assign w_ev = (ACTIVE_FALL != 0 ? (~w_s & r_sd) : (w_s & ~r_sd)) & mask;
  assign irq_out = r_state == PULSE;
  assign busy = r_state != IDLE;
  assign irq_id = r_id;
  assign pending = r_pending;
  assign overflow = r_overflow;
  assign ack_timeout = r_to;
  // Scan from the far end so the last hit is the highest-priority candidate.
  always_comb begin
    w_win = '0;
    w_j = '0;
    for (int k = N_CH; k >= 1; k--) begin
      w_j = IW'(RR_MODE != 0 ? (int'(r_last) + k) % N_CH : k - 1);
      if (r_pending[w_j]) w_win = w_j;
    end
  end
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_acked = r_acked;
    w_to = 1'b0;
    w_grant = 1'b0;
    w_clr = '0;
    case (r_state)
      IDLE: if (|r_pending) begin
        w_grant = 1'b1;
        w_clr[w_win] = 1'b1;
        w_cnt = 16'(PULSE_US);
        w_acked = 1'b0;
        w_state = PULSE;
      end
      PULSE: begin
        w_acked = r_acked | ack;
        if (t1us && r_cnt != 16'd0) begin
          w_cnt = r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            w_cnt = 16'(ACK_TO_US);
            w_state = w_acked ? IDLE : WAIT_ACK;
          end
        end
      end
      WAIT_ACK: if (ack) w_state = IDLE;
      else if (t1us && r_cnt != 16'd0) begin
        w_cnt = r_cnt - 16'd1;
        if (r_cnt == 16'd1) begin
          w_to = 1'b1;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sync <= '0;
      r_sd <= '0;
      r_cnt <= '0;
      r_acked <= 1'b0;
      r_id <= '0;
      r_last <= IW'(N_CH - 1);
      r_pending <= '0;
      r_overflow <= '0;
      r_to <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sync <= {r_sync[SYNC_STAGES-2:0], int_in};
      r_sd <= w_s;
      r_cnt <= w_cnt;
      r_acked <= w_acked;
      if (w_grant) begin
        r_id <= w_win;
        r_last <= w_win;
      end
      r_pending <= (r_pending & ~w_clr) | w_ev;
      r_overflow <= (clr_flags ? '0 : r_overflow) | (w_ev & r_pending & ~w_clr);
      r_to <= (r_to & ~clr_flags) | w_to;
    end
  end
endmodule

// File: doc/int_control_n.md
# int_control_n

Parametrised interrupt concentrator, the successor to the single-input interrupt stretcher between the backplane BUS_INT lines and the DSP PPI flag pins. Accepts N_CH asynchronous interrupt lines. Each line is synchronised, edge-detected, masked and latched as pending. Pending requests are served one at a time by fixed or round-robin priority. Each grant produces a stretched pulse, timed in 1 µs ticks, plus a channel ID, and the block then waits for a DSP acknowledge with a timeout.

## Interface
- N_CH, 4 — number of interrupt inputs, 1..16.
- SYNC_STAGES, 2 — synchroniser depth per input, ≥2.
- ACTIVE_FALL, 0 — 0: rising edge is an event; 1: falling edge is an event (all channels).
- PULSE_US, 10 — irq_out high time in t1us ticks, 1..255.
- ACK_TO_US, 1000 — acknowledge timeout in t1us ticks, 1..65535.
- RR_MODE, 0 — 0: fixed priority (lowest index wins); 1: round-robin.
- clk  in  1  system clock (20 MHz domain); the only clock.
- reset  in  1  synchronous, active-high reset.
- t1us  in  1  one-clk strobe, once per microsecond.
- int_in  in  N_CH  asynchronous interrupt lines.
- mask  in  N_CH  1 = channel enabled; static or slowly changing, sampled every clk.
- ack  in  1  one-clk acknowledge from DSP (already synchronous).
- clr_flags  in  1  one-clk strobe; clears overflow and ack_timeout.
- irq_out  out  1  stretched interrupt pulse to DSP.
- irq_id  out  clog2(N_CH) (min 1)  channel being served; held from grant until return to IDLE.
- busy  out  1  high in PULSE and WAIT_ACK.
- pending  out  N_CH  latched, not-yet-granted events.
- overflow  out  N_CH  sticky: event arrived while that channel was already pending.
- ack_timeout  out  1  sticky: WAIT_ACK expired without ack.

## Operation
- Each int_in passes a SYNC_STAGES flop chain, then one extra flop for edge detection. The event is `s & ~s_d` (rising) or `~s & s_d` (falling).
- Event with mask=0: discarded; no pending, no overflow.
- Event with mask=1:
  - pending clear → set pending.
  - pending already set → pending stays set and the overflow bit for that channel sets.
- Clearing mask does not clear existing pending bits.
- FSM states:
  - IDLE: if any pending bit is set, select a winner, latch irq_id, clear that pending bit, set irq_out=1, load the counter with PULSE_US, go to PULSE.
  - PULSE: decrement the counter on each t1us. When the counter reaches 0 on a tick, set irq_out=0, load the counter with ACK_TO_US, go to WAIT_ACK.
  - WAIT_ACK: ack → IDLE. Otherwise decrement the counter on each t1us; reaching 0 sets ack_timeout and goes to IDLE.
- Ack rules:
  - Ack in PULSE is remembered. At the end of the pulse the FSM goes straight to IDLE and skips WAIT_ACK.
  - Ack in IDLE is ignored.
- Winner selection:
  - Fixed priority: lowest-index pending bit.
  - Round-robin: first pending bit at an index above the last granted, wrapping modulo N_CH. The last-granted pointer resets to N_CH-1, so the first search starts at channel 0.
- Same-cycle event and grant clear on the same channel: the set wins. The pending bit stays 1 and overflow is not set.
- clr_flags in the same cycle as a new overflow or timeout: the set wins.
- Counters are 16 bits. No underflow: the counter only decrements while it is non-zero.

## Timing
- Reset values: irq_out=0, irq_id=0, busy=0, pending=0, overflow=0, ack_timeout=0, FSM=IDLE, synchroniser and edge flops=0.
- After reset, an input held at 1 with ACTIVE_FALL=0 is seen as one rising event. Software masks channels until their lines are stable.
- Latency from an int_in transition to the pending bit: SYNC_STAGES+1 clk; the pending bit is visible on the following clk.
- Latency from pending visible to irq_out=1: 1 clk when the FSM is in IDLE.
- irq_out high time: from grant up to the PULSE_US-th t1us strobe seen in PULSE. The first tick period is partial, so the high time is (PULSE_US-1) to PULSE_US µs.
- Consecutive grants are separated by at least 1 clk with irq_out=0 (the IDLE cycle).
- Reset asserted mid-operation: all state returns to reset values on the next clk edge, and irq_out drops in that same cycle.

## Test plan
- N_CH=4, fixed priority: pulse int_in[2] high for 1 µs → pending[2] after 3 clk; irq_out high for 9–10 µs with irq_id=2; ack after 20 µs → IDLE, busy=0.
- Fixed priority: int_in[1] and int_in[3] rise in the same clk → grant 1 first, then 3 after ack; pending goes 1010→1000→0000.
- RR_MODE=1: channels 0 and 1 permanently re-triggered → grants alternate 0,1,0,1; a fixed-priority build gives 0,0,0.
- mask=0000 with events on all channels → no pending, irq_out stays 0. Two events on channel 0 before it is granted → overflow[0]=1 until clr_flags.
- No ack, ACK_TO_US=5 → ack_timeout=1 about 5 µs after irq_out falls, FSM back in IDLE, next pending channel served. Ack during PULSE → no WAIT_ACK phase.
- Reset asserted during PULSE → irq_out=0 and all outputs at reset values within 1 clk. An event in the same clk as its grant clear leaves pending set with overflow=0.
